datapath_reset_sequencer: RTL and testbench

DATAPATH_RESET_SEQUENCER -- requirements
Module: datapath_reset_sequencer

---
 rtl/datapath_ctrl_pkg.sv | 42 ++++
 rtl/seq_timer.sv | 34 +++
 rtl/datapath_reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_datapath_reset_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and bus bit positions for the datapath reset sequencer.
// States carry an ST_ prefix so they do not collide with the controlBus indices.
package datapath_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_LOCK = 4'd1,
        ST_SETTLE    = 4'd2,
        ST_GTX_RST   = 4'd3,
        ST_EN_DLY    = 4'd4,
        ST_DP_RST    = 4'd5,
        ST_WAIT_RDY  = 4'd6,
        ST_RUN       = 4'd7,
        ST_FAIL      = 4'd8
    } state_e;

    localparam int unsigned TX_RDY  = 0;
    localparam int unsigned RX_RDY  = 3;
    localparam int unsigned LOCK_A  = 2;
    localparam int unsigned LOCK_B  = 5;

    localparam int unsigned GTX_RST = 3;
    localparam int unsigned DP_EN   = 4;
    localparam int unsigned DP_RST  = 1;

    function automatic logic [31:0] ctl_for(input state_e s);
        logic [31:0] c;
        c = '0;
        case (s)
            ST_GTX_RST: c[GTX_RST] = 1'b1;
            ST_DP_RST: begin
                c[DP_EN]  = 1'b1;
                c[DP_RST] = 1'b1;
            end
            ST_WAIT_RDY,
            ST_RUN: c[DP_EN] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that holds at zero; expired_o flags the terminal count.
module seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/datapath_reset_sequencer.sv
// Brings the datapath out of reset after MMCM lock, with retry on
// ready timeout or link loss; every output is registered from next state.
module datapath_reset_sequencer
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC   = 680,
    parameter int unsigned GTXRST_CYC   = 6,
    parameter int unsigned ENDLY_CYC    = 10,
    parameter int unsigned PULSE_CYC    = 4,
    parameter int unsigned READY_TO_CYC = 40000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        sysclk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] status_i,
    output logic [31:0] control_o,
    output logic        ready_o,
    output logic        fail_o,
    output logic [1:0]  retry_o,
    output logic [3:0]  state_o
);

    localparam int unsigned M01  =
        (SETTLE_CYC > GTXRST_CYC) ? SETTLE_CYC : GTXRST_CYC;
    localparam int unsigned M23  =
        (ENDLY_CYC > PULSE_CYC) ? ENDLY_CYC : PULSE_CYC;
    localparam int unsigned M012 = (M01 > M23) ? M01 : M23;
    localparam int unsigned MAXC =
        (M012 > READY_TO_CYC) ? M012 : READY_TO_CYC;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

    state_e      state_q;
    state_e      state_d;
    logic [1:0]  retry_q;
    logic [1:0]  retry_d;
    logic [31:0] ctl_q;
    logic        rdy_q;
    logic        fail_q;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_exp;

    logic lock;
    logic link;
    logic can_retry;
    logic unused_status;

    assign lock      = status_i[LOCK_A] & status_i[LOCK_B];
    assign link      = status_i[TX_RDY] & status_i[RX_RDY];
    assign can_retry = (retry_q < RETRY_MAX);

    assign unused_status = ^status_i;

    // Counter is preloaded with N-1 so a phase spans exactly N cycles.
    function automatic logic [CW-1:0] phase_len(input state_e s);
        logic [CW-1:0] v;
        v = '0;
        case (s)
            ST_SETTLE:   v = CW'(SETTLE_CYC - 1);
            ST_GTX_RST:  v = CW'(GTXRST_CYC - 1);
            ST_EN_DLY:   v = CW'(ENDLY_CYC - 1);
            ST_DP_RST:   v = CW'(PULSE_CYC - 1);
            ST_WAIT_RDY: v = CW'(READY_TO_CYC - 1);
            default:     v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (!start_i) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock) state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!lock)        state_d = ST_WAIT_LOCK;
                    else if (tmr_exp) state_d = ST_GTX_RST;
                end
                ST_GTX_RST: begin
                    if (!lock)        state_d = ST_WAIT_LOCK;
                    else if (tmr_exp) state_d = ST_EN_DLY;
                end
                ST_EN_DLY: begin
                    if (!lock)        state_d = ST_WAIT_LOCK;
                    else if (tmr_exp) state_d = ST_DP_RST;
                end
                ST_DP_RST: begin
                    if (!lock)        state_d = ST_WAIT_LOCK;
                    else if (tmr_exp) state_d = ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (!lock) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (link) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else if (tmr_exp) begin
                        if (can_retry) begin
                            state_d = ST_GTX_RST;
                            retry_d = retry_q + 2'd1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_RUN: begin
                    if (!lock) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (!link) begin
                        if (can_retry) begin
                            state_d = ST_GTX_RST;
                            retry_d = retry_q + 2'd1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // No state re-enters itself, so any change of state is a phase entry.
    assign tmr_load = (state_d != state_q);
    assign tmr_val  = phase_len(state_d);

    seq_timer #(
        .W (CW)
    ) u_timer (
        .clk_i      (sysclk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            ctl_q   <= '0;
            rdy_q   <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            ctl_q   <= ctl_for(state_d);
            rdy_q   <= (state_d == ST_RUN);
            fail_q  <= (state_d == ST_FAIL);
        end
    end

    assign control_o = ctl_q;
    assign ready_o   = rdy_q;
    assign fail_o    = fail_q;
    assign retry_o   = retry_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_datapath_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected outputs tagged with a cycle,
// a negedge monitor compares them when that cycle arrives.
`timescale 1ns/1ps
module tb_datapath_reset_sequencer;

    localparam logic [31:0] C_0   = 32'h0;
    localparam logic [31:0] C_GTX = 32'h8;
    localparam logic [31:0] C_EN  = 32'h10;
    localparam logic [31:0] C_DP  = 32'h12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] status;
    logic [31:0] control_o;
    logic        ready_o;
    logic        fail_o;
    logic [1:0]  retry_o;
    logic [3:0]  state_o;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          at;
        logic [63:0] tag;
        logic [31:0] ctl;
        logic        rdy;
        logic        fl;
        logic [1:0]  rt;
        logic [3:0]  st;
    } exp_t;

    exp_t q[$];

    datapath_reset_sequencer #(
        .SETTLE_CYC   (680),
        .GTXRST_CYC   (6),
        .ENDLY_CYC    (10),
        .PULSE_CYC    (4),
        .READY_TO_CYC (200),
        .MAX_RETRY    (3)
    ) dut (
        .sysclk_i  (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .status_i  (status),
        .control_o (control_o),
        .ready_o   (ready_o),
        .fail_o    (fail_o),
        .retry_o   (retry_o),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_at(input int at, input logic [63:0] tag,
                          input logic [31:0] c, input logic r,
                          input logic f, input logic [1:0] rt,
                          input logic [3:0] st);
        exp_t e;
        e.at = at; e.tag = tag; e.ctl = c;
        e.rdy = r; e.fl = f; e.rt = rt; e.st = st;
        q.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        vectors++;
        if (e.at != cyc ||
            {control_o, ready_o, fail_o, retry_o, state_o} !==
            {e.ctl, e.rdy, e.fl, e.rt, e.st}) begin
            miscompares++;
            $display("FAIL %s cyc=%0d(want %0d): got ctl=%h rdy=%0b fail=%0b retry=%0d st=%0d, want ctl=%h rdy=%0b fail=%0b retry=%0d st=%0d",
                     e.tag, cyc, e.at, control_o, ready_o, fail_o, retry_o,
                     state_o, e.ctl, e.rdy, e.fl, e.rt, e.st);
        end
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                compare(q[i]);
                q.delete(i);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int n, t0, r, d, w, l, s, a, f, s2, guard;
        rst_n  = 1'b0;
        start  = 1'b0;
        status = 32'h0;
        repeat (3) @(negedge clk);
        exp_at(cyc + 1, "rst", C_0, 0, 0, 2'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = cyc;
        exp_at(n + 2, "idle", C_0, 0, 0, 2'd0, 4'd0);
        wait_until(n + 3);
        start = 1'b1;
        exp_at(n + 4, "wlock", C_0, 0, 0, 2'd0, 4'd1);

        // lock at t0, full bring-up
        t0 = n + 8;
        wait_until(t0);
        status = 32'h24;
        exp_at(t0 + 1,   "settle0", C_0,   0, 0, 2'd0, 4'd2);
        exp_at(t0 + 680, "settleN", C_0,   0, 0, 2'd0, 4'd2);
        exp_at(t0 + 681, "gtx0",    C_GTX, 0, 0, 2'd0, 4'd3);
        exp_at(t0 + 686, "gtxN",    C_GTX, 0, 0, 2'd0, 4'd3);
        exp_at(t0 + 687, "endly0",  C_0,   0, 0, 2'd0, 4'd4);
        exp_at(t0 + 696, "endlyN",  C_0,   0, 0, 2'd0, 4'd4);
        exp_at(t0 + 697, "dprst0",  C_DP,  0, 0, 2'd0, 4'd5);
        exp_at(t0 + 700, "dprstN",  C_DP,  0, 0, 2'd0, 4'd5);
        exp_at(t0 + 701, "wrdy0",   C_EN,  0, 0, 2'd0, 4'd6);
        exp_at(t0 + 797, "wrdyN",   C_EN,  0, 0, 2'd0, 4'd6);
        wait_until(t0 + 797);
        status = 32'h2D;
        exp_at(t0 + 798, "run", C_EN, 1, 0, 2'd0, 4'd7);

        // one-cycle rx ready glitch in RUN
        r = t0 + 820;
        wait_until(r);
        status = 32'h25;
        exp_at(r + 1,  "rgtx0",  C_GTX, 0, 0, 2'd1, 4'd3);
        exp_at(r + 6,  "rgtxN",  C_GTX, 0, 0, 2'd1, 4'd3);
        exp_at(r + 7,  "rendly", C_0,   0, 0, 2'd1, 4'd4);
        exp_at(r + 17, "rdprst", C_DP,  0, 0, 2'd1, 4'd5);
        exp_at(r + 21, "rwrdy",  C_EN,  0, 0, 2'd1, 4'd6);
        exp_at(r + 22, "rrun",   C_EN,  1, 0, 2'd0, 4'd7);
        @(negedge clk);
        status = 32'h2D;

        // ready loss, then lock B lost in WAIT_RDY
        d = r + 40;
        wait_until(d);
        status = 32'h24;
        exp_at(d + 1, "dgtx", C_GTX, 0, 0, 2'd1, 4'd3);
        w = d + 50;
        exp_at(w, "dwrdy", C_EN, 0, 0, 2'd1, 4'd6);
        wait_until(w);
        status = 32'h04;
        exp_at(w + 1, "lkloss", C_0, 0, 0, 2'd1, 4'd1);
        l = w + 10;
        wait_until(l);
        status = 32'h24;
        exp_at(l + 1,   "ls0",   C_0,   0, 0, 2'd1, 4'd2);
        exp_at(l + 680, "lsN",   C_0,   0, 0, 2'd1, 4'd2);
        exp_at(l + 681, "lgtx",  C_GTX, 0, 0, 2'd1, 4'd3);
        exp_at(l + 701, "lwrdy", C_EN,  0, 0, 2'd1, 4'd6);
        exp_at(l + 900, "lwrdyN", C_EN, 0, 0, 2'd1, 4'd6);

        // timeout coincides with lock A loss
        wait_until(l + 900);
        status = 32'h20;
        exp_at(l + 901, "tolock", C_0, 0, 0, 2'd1, 4'd1);
        wait_until(l + 910);
        start = 1'b0;
        exp_at(l + 911, "stop1", C_0, 0, 0, 2'd0, 4'd0);

        // never ready: three retries then FAIL
        s = l + 915;
        wait_until(s);
        start  = 1'b1;
        status = 32'h24;
        a = s + 702;
        exp_at(s + 1,   "fwl",   C_0,   0, 0, 2'd0, 4'd1);
        exp_at(s + 2,   "fset",  C_0,   0, 0, 2'd0, 4'd2);
        exp_at(a,       "fwr0",  C_EN,  0, 0, 2'd0, 4'd6);
        exp_at(a + 199, "fwr0N", C_EN,  0, 0, 2'd0, 4'd6);
        exp_at(a + 200, "retry1", C_GTX, 0, 0, 2'd1, 4'd3);
        exp_at(a + 420, "retry2", C_GTX, 0, 0, 2'd2, 4'd3);
        exp_at(a + 640, "retry3", C_GTX, 0, 0, 2'd3, 4'd3);
        exp_at(a + 859, "fwr3N", C_EN,  0, 0, 2'd3, 4'd6);
        exp_at(a + 860, "fail",  C_0,   0, 1, 2'd3, 4'd8);
        exp_at(a + 900, "sticky", C_0,  0, 1, 2'd3, 4'd8);
        wait_until(a + 870);
        status = 32'h2D;
        f = a + 910;
        wait_until(f);
        start = 1'b0;
        exp_at(f + 1, "stopF", C_0, 0, 0, 2'd0, 4'd0);

        // reset asserted during DP_RST
        s2 = f + 5;
        wait_until(s2);
        start  = 1'b1;
        status = 32'h24;
        exp_at(s2 + 699, "predp", C_DP, 0, 0, 2'd0, 4'd5);
        wait_until(s2 + 699);
        rst_n = 1'b0;
        exp_at(s2 + 700, "rstdp", C_0, 0, 0, 2'd0, 4'd0);
        wait_until(s2 + 702);
        rst_n = 1'b1;
        exp_at(s2 + 703, "postrst", C_0, 0, 0, 2'd0, 4'd1);

        guard = 0;
        while (q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        foreach (q[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL %s never checked (due cyc %0d, now %0d)",
                     q[i].tag, q[i].at, cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
